// File: rtl/sqrt_ctrl_if.sv
// -----------------------------------------------------------------------------
// sqrt_ctrl_if
//   Bundles the request/status and datapath-control signals of the integer
//   square-root control unit.
//
//   start     requester -> ctrl   request a new root (sampled only in IDLE)
//   sub_neg   datapath  -> ctrl   trial subtraction negative (1 = do not subtract)
//   busy      ctrl -> requester   operation in progress (LOAD, CALC, UPDATE)
//   done      ctrl -> requester   one-cycle pulse, result registers valid
//   ld_in     ctrl -> datapath    load radicand, clear remainder and root
//   en_shift  ctrl -> datapath    shift next radicand bit pair into remainder
//   en_rem    ctrl -> datapath    remainder register enable
//   sel_sub   ctrl -> datapath    remainder mux: 1 = difference, 0 = shifted value
//   en_root   ctrl -> datapath    root register enable (shift left, insert root_bit)
//   root_bit  ctrl -> datapath    new root LSB
//   iter_cnt  ctrl -> datapath    current iteration index
//
//   master : requester/datapath side.  slave : the control unit.
// -----------------------------------------------------------------------------
interface sqrt_ctrl_if #(
  parameter int CNT_W = 2
);
  logic             start;
  logic             sub_neg;
  logic             busy;
  logic             done;
  logic             ld_in;
  logic             en_shift;
  logic             en_rem;
  logic             sel_sub;
  logic             en_root;
  logic             root_bit;
  logic [CNT_W-1:0] iter_cnt;

  modport master (
    output start, sub_neg,
    input  busy, done, ld_in, en_shift, en_rem, sel_sub, en_root, root_bit, iter_cnt
  );

  modport slave (
    input  start, sub_neg,
    output busy, done, ld_in, en_shift, en_rem, sel_sub, en_root, root_bit, iter_cnt
  );
endinterface

// File: rtl/sqrt_ctrl.sv
// -----------------------------------------------------------------------------
// sqrt_ctrl
//   Control unit for a digit-by-digit integer square-root datapath. Issues one
//   load, then ITER pairs of CALC (shift bit pair, form trial difference) and
//   UPDATE (commit remainder and one root bit). Holds no arithmetic: the sign
//   of the trial subtraction comes back from the datapath on sub_neg.
//
//   Parameters
//     WIDTH  radicand width, even and >= 4
//     ITER   iterations, one root bit each, >= 2
//     CNT_W  iteration counter width; must match the interface CNT_W
//
//   Ports
//     clk    rising-edge clock
//     clr    synchronous active-low reset
//     bus    sqrt_ctrl_if.slave (start/sub_neg in; status and enables out)
//
//   Timing: start sampled in IDLE at edge k -> LOAD from edge k, DONE from
//   edge k+1+2*ITER, IDLE again from edge k+2+2*ITER.
// -----------------------------------------------------------------------------
module sqrt_ctrl #(
  parameter int WIDTH = 8,
  parameter int ITER  = WIDTH / 2,
  parameter int CNT_W = $clog2(ITER)
) (
  input  logic        clk,
  input  logic        clr,
  sqrt_ctrl_if.slave  bus
);

  // Elaboration-time parameter sanity.
  generate
    if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
      $error("sqrt_ctrl: WIDTH must be even and >= 4");
    end
    if (ITER < 2) begin : g_bad_iter
      $error("sqrt_ctrl: ITER must be >= 2");
    end
    if (CNT_W < 1 || (1 << CNT_W) < ITER) begin : g_bad_cnt
      $error("sqrt_ctrl: CNT_W too narrow for ITER");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CALC,
    S_UPDATE,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  logic busy, done, ld_in, en_shift, en_rem, sel_sub, en_root, root_bit;

  // ---------------------------------------------------------------------------
  // State and counter registers. clr wins over everything, in every state.
  // ---------------------------------------------------------------------------
  // NOTE: registered state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and Moore output decode. sub_neg is looked at only inside the
  // UPDATE branch, so an unknown value in any other state cannot leak out.
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first; a path that leaves
  // one unassigned would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    busy     = 1'b0;
    done     = 1'b0;
    ld_in    = 1'b0;
    en_shift = 1'b0;
    en_rem   = 1'b0;
    sel_sub  = 1'b0;
    en_root  = 1'b0;
    root_bit = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = S_LOAD;
      end

      S_LOAD: begin
        busy    = 1'b1;
        ld_in   = 1'b1;
        cnt_d   = '0;
        state_d = S_CALC;
      end

      S_CALC: begin
        busy     = 1'b1;
        en_shift = 1'b1;
        state_d  = S_UPDATE;
      end

      S_UPDATE: begin
        busy     = 1'b1;
        en_rem   = 1'b1;
        en_root  = 1'b1;
        // A non-negative trial difference means this root bit is 1 and the
        // difference replaces the remainder.
        sel_sub  = ~bus.sub_neg;
        root_bit = ~bus.sub_neg;
        if (cnt_q == LAST_ITER) begin
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = S_CALC;
        end
      end

      S_DONE: begin
        done    = 1'b1;
        // iter_cnt stays at ITER-1 while done is shown, then returns to 0 so
        // IDLE presents an all-zero output vector.
        cnt_d   = '0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.ld_in    = ld_in;
  assign bus.en_shift = en_shift;
  assign bus.en_rem   = en_rem;
  assign bus.sel_sub  = sel_sub;
  assign bus.en_root  = en_root;
  assign bus.root_bit = root_bit;
  assign bus.iter_cnt = cnt_q;

endmodule

// File: tb/tb_sqrt_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sqrt_ctrl
//   Directed bench for sqrt_ctrl (WIDTH=8, ITER=4). Stimulus tasks push the
//   expected UPDATE records (root bit, iteration index) and done cycles into
//   queues; a monitor process samples on the falling edge, pops and compares
//   whenever the DUT raises en_root or done, and checks per-cycle decode rules.
// -----------------------------------------------------------------------------
module tb_sqrt_ctrl;
  localparam int WIDTH = 8;
  localparam int ITER  = 4;
  localparam int CNT_W = 2;

  logic clk = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  sqrt_ctrl_if #(.CNT_W(CNT_W)) bus ();

  sqrt_ctrl #(.WIDTH(WIDTH), .ITER(ITER), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  typedef struct packed {
    logic             root_bit;
    logic [CNT_W-1:0] iter;
  } upd_t;

  upd_t exp_upd[$];
  int   exp_done[$];

  int cyc      = 0;
  int n_checks = 0;
  int n_errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [9:0] outs();
    return {bus.busy, bus.done, bus.ld_in, bus.en_shift, bus.en_rem,
            bus.sel_sub, bus.en_root, bus.root_bit, bus.iter_cnt};
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  initial begin
    bit   prev_busy;
    int   nen;
    upd_t e;
    int   dc;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      nen = int'(bus.ld_in) + int'(bus.en_shift) + int'(bus.en_rem);
      check("one_enable", nen, bus.busy ? 1 : 0);
      if (!bus.en_root) check("mux_quiet", {bus.sel_sub, bus.root_bit}, 0);
      if (bus.ld_in) check("load_after_idle", prev_busy, 0);
      if (bus.en_root) begin
        if (exp_upd.size() == 0) begin
          check("update_expected", exp_upd.size(), 1);
        end else begin
          e = exp_upd.pop_front();
          check("root_bit", bus.root_bit, e.root_bit);
          check("sel_sub", bus.sel_sub, e.root_bit);
          check("iter_cnt", bus.iter_cnt, e.iter);
          check("en_rem_in_update", bus.en_rem, 1);
        end
      end
      if (bus.done) begin
        check("done_not_busy", bus.busy, 0);
        check("done_iter_cnt", bus.iter_cnt, ITER - 1);
        if (exp_done.size() == 0) begin
          check("done_expected", exp_done.size(), 1);
        end else begin
          dc = exp_done.pop_front();
          check("done_cycle", cyc, dc);
        end
      end
      prev_busy = bus.busy;
    end
  end

  // ---------------------------------------------------------------------------
  // One operation. pat[i] is sub_neg during UPDATE i; other cycles get random
  // sub_neg. noisy pulses start mid-operation. abort_n >= 0 pulls clr low in
  // cycle abort_n after LOAD (0 = LOAD, UPDATE i = 2+2i).
  // ---------------------------------------------------------------------------
  task automatic run_op(input logic [3:0] pat, input bit noisy, input int abort_n);
    int c;
    @(negedge clk);
    bus.start = 1'b1;
    c = cyc;
    for (int i = 0; i < ITER; i++)
      if (abort_n < 0 || 2 + 2 * i <= abort_n)
        exp_upd.push_back(upd_t'({~pat[i], CNT_W'(i)}));
    if (abort_n < 0) exp_done.push_back(c + 10);
    @(posedge clk); #1;
    for (int n = 0; n < 10; n++) begin
      bus.start   = noisy && (n == 2 || n == 6);
      bus.sub_neg = (n >= 2 && n <= 8 && n % 2 == 0) ? pat[(n - 2) / 2]
                                                     : 1'($urandom_range(0, 1));
      if (n == abort_n) clr = 1'b0;
      @(posedge clk); #1;
      if (n == abort_n) begin
        @(negedge clk);
        check("abort_outputs", outs(), 0);
        clr       = 1'b1;
        bus.start = 1'b0;
        return;
      end
    end
    bus.start = 1'b0;
  endtask

  // start held high: three operations, LOAD every 11 cycles.
  task automatic run_b2b(input logic [3:0] p0, input logic [3:0] p1, input logic [3:0] p2);
    logic [3:0] pats [3];
    int c, m, j;
    pats[0] = p0; pats[1] = p1; pats[2] = p2;
    @(negedge clk);
    bus.start = 1'b1;
    c = cyc;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < ITER; i++)
        exp_upd.push_back(upd_t'({~pats[k][i], CNT_W'(i)}));
      exp_done.push_back(c + 10 + 11 * k);
    end
    @(posedge clk); #1;
    for (int n = 0; n < 33; n++) begin
      m = n % 11;
      j = n / 11;
      bus.start   = (n < 32);
      bus.sub_neg = (m >= 2 && m <= 8 && m % 2 == 0) ? pats[j][(m - 2) / 2]
                                                     : 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    bus.start   = 1'b1;
    bus.sub_neg = 1'b0;
    clr         = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", outs(), 0);
    clr       = 1'b1;
    bus.start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("idle_hold", outs(), 0);
    end

    run_op(4'b1010, 1'b0, -1);   // sub_neg 0,1,0,1 -> root bits 1,0,1,0
    run_op(4'b0110, 1'b1, -1);   // start pulses ignored while busy
    run_op(4'b0011, 1'b0, 6);    // reset in UPDATE of iteration 2
    run_op(4'b1111, 1'b0, -1);   // full sequence after abort
    run_op(4'b0000, 1'b0, -1);
    run_b2b(4'b0101, 4'b1001, 4'b1100);

    repeat (3) @(negedge clk);
    check("idle_after_b2b", outs(), 0);
    check("upd_queue_empty", exp_upd.size(), 0);
    check("done_queue_empty", exp_done.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
